shifter_arbiter: RTL and testbench

SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

---
 rtl/shifter_arbiter.sv | 110 +++++++++++
 tb/tb_shifter_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Two-port round-robin front end sharing one sll and one sra 32-bit log shifter.
// Latency: one cycle from accepting edge to resp_valid; one result per cycle sustained.
// Backpressure: a full output register with resp_ready low stalls both requesters.
module shifter_arbiter #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_operand,
   input  logic [4:0]  req0_shamt,
   input  logic        req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_operand,
   input  logic [4:0]  req1_shamt,
   input  logic        req1_op,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_id
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        prio;
   logic        can_accept;
   logic        grant0, grant1;
   logic        accept;
   logic        sel;
   logic [31:0] opnd;
   logic [4:0]  shamt;
   logic        op;
   logic        sign;
   logic [31:0] l16, l8, l4, l2, l1;
   logic [31:0] r16, r8, r4, r2, r1;
   logic [31:0] result;

   // Arbitration: a lone valid port always wins, a tie goes to the priority holder.
   // Ready is masked by reset_n so nothing can appear accepted while reset is held.
   always_comb begin
      can_accept = (state_q == EMPTY) || resp_ready;
      grant0     = req0_valid && (!req1_valid || (prio == 1'b0));
      grant1     = req1_valid && (!req0_valid || (prio == 1'b1));
      req0_ready = reset_n && can_accept && grant0;
      req1_ready = reset_n && can_accept && grant1;
      accept     = req0_ready || req1_ready;
      sel        = grant1;
   end

   // Steer the granted port's payload into the single shared shifter pair.
   always_comb begin
      opnd  = sel ? req1_operand : req0_operand;
      shamt = sel ? req1_shamt   : req0_shamt;
      op    = sel ? req1_op      : req0_op;
      sign  = opnd[31];
   end

   // Five-stage logarithmic shifters (16/8/4/2/1); sll zero-fills, sra sign-fills.
   always_comb begin
      l16 = shamt[4] ? {opnd[15:0], 16'd0} : opnd;
      l8  = shamt[3] ? {l16[23:0],  8'd0}  : l16;
      l4  = shamt[2] ? {l8[27:0],   4'd0}  : l8;
      l2  = shamt[1] ? {l4[29:0],   2'd0}  : l4;
      l1  = shamt[0] ? {l2[30:0],   1'b0}  : l2;
      r16 = shamt[4] ? {{16{sign}}, opnd[31:16]} : opnd;
      r8  = shamt[3] ? {{8{sign}},  r16[31:8]}   : r16;
      r4  = shamt[2] ? {{4{sign}},  r8[31:4]}    : r8;
      r2  = shamt[1] ? {{2{sign}},  r4[31:2]}    : r4;
      r1  = shamt[0] ? {sign,       r2[31:1]}    : r2;
      result = op ? r1 : l1;
   end

   // Output register occupancy: an accept always leaves it full (drain and refill
   // in the same cycle), otherwise a taken result empties it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (accept) state_d = FULL;
                  else if (resp_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   // Result capture and pointer update; data is held untouched unless a new accept occurs.
   // The pointer always moves to the port that was not granted, so a waiting port wins next.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resp_data <= 32'd0;
         resp_id   <= 1'b0;
         prio      <= RR_INIT;
      end else if (accept) begin
         resp_data <= result;
         resp_id   <= sel;
         prio      <= ~sel;
      end
   end

   assign resp_valid = (state_q == FULL);

endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        req0_valid = 1'b0, req0_op = 1'b0;
   logic [31:0] req0_operand = 32'd0;
   logic [4:0]  req0_shamt = 5'd0;
   logic        req1_valid = 1'b0, req1_op = 1'b0;
   logic [31:0] req1_operand = 32'd0;
   logic [4:0]  req1_shamt = 5'd0;
   logic        resp_ready = 1'b0;
   logic        req0_ready, req1_ready, resp_valid, resp_id;
   logic [31:0] resp_data;

   shifter_arbiter #(.RR_INIT(1'b0)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operand(req0_operand),
      .req0_shamt(req0_shamt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operand(req1_operand),
      .req1_shamt(req1_shamt), .req1_op(req1_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        id;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   logic m_full = 1'b0;
   logic m_prio = 1'b0;
   int   w0 = 0, w1 = 0;

   function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s, input logic op);
      logic signed [31:0] sx;
      sx = x;
      if (op) return sx >>> s;
      return x << s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bound(input string name, input int val, input int maxv);
      total++;
      if (val > maxv) begin
         bad++;
         $display("FAIL %s: waited %0d accepting cycles, limit %0d", name, val, maxv);
      end
   endtask

   // One clock of stimulus: predict handshakes from the rules, check ready, record accepted work.
   task automatic step(output logic a0, output logic a1);
      logic can, g0, g1;
      exp_t e;
      @(negedge clock);
      can = !m_full || resp_ready;
      g0  = req0_valid && (!req1_valid || m_prio == 1'b0);
      g1  = req1_valid && !g0;
      a0  = can && g0;
      a1  = can && g1;
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, a0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, a1});
      if (a1) begin
         e.id = 1'b1; e.data = ref_shift(req1_operand, req1_shamt, req1_op);
      end else begin
         e.id = 1'b0; e.data = ref_shift(req0_operand, req0_shamt, req0_op);
      end
      @(posedge clock);
      if (a0 || a1) begin
         sb.push_back(e);
         m_full = 1'b1;
         m_prio = a0 ? 1'b1 : 1'b0;
         if (a0) begin chk_bound("fair0", w0, 1); w0 = 0; end
         if (a1) begin chk_bound("fair1", w1, 1); w1 = 0; end
         if (a1 && req0_valid) w0++;
         if (a0 && req1_valid) w1++;
      end else if (resp_ready) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic new0();
      req0_operand = $urandom; req0_shamt = 5'($urandom_range(0, 31)); req0_op = 1'($urandom_range(0, 1));
   endtask

   task automatic new1();
      req1_operand = $urandom; req1_shamt = 5'($urandom_range(0, 31)); req1_op = 1'($urandom_range(0, 1));
   endtask

   // Monitor: every cycle the output must match the oldest outstanding result.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n) begin
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, (sb.size() != 0)});
            if (resp_valid && sb.size() != 0) begin
               chk("resp_data", resp_data, sb[0].data);
               chk("resp_id", {31'd0, resp_id}, {31'd0, sb[0].id});
               if (resp_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      logic a0, a1;
      logic [31:0] held_data;
      logic        held_id;

      // Reset values, with a request pending to prove ready stays low.
      #2 reset_n = 1'b0;
      req0_valid = 1'b1;
      #1;
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      chk("rst_data", resp_data, 32'd0);
      chk("rst_id", {31'd0, resp_id}, 32'd0);
      reset_n = 1'b1;
      req0_valid = 1'b0;

      // Both ports streaming: strict alternation starting at port 0, no bubbles.
      new0(); new1();
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(a0, a1);
         chk("rr_seq", {31'd0, resp_id}, i % 2);
         chk("rr_nobubble", {31'd0, resp_valid}, 32'd1);
         if (a0) new0();
         if (a1) new1();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(a0, a1);

      // Port 0 alone, sra by 1 on a negative operand.
      req0_valid = 1'b1; req0_operand = 32'h8000_0001; req0_shamt = 5'd1; req0_op = 1'b1;
      step(a0, a1);
      req0_valid = 1'b0;
      #3;
      chk("sra1_valid", {31'd0, resp_valid}, 32'd1);
      chk("sra1_data", resp_data, 32'hC000_0000);
      chk("sra1_id", {31'd0, resp_id}, 32'd0);

      // Port 1 alone: sll by 31, then shamt 0 passes the operand through.
      req1_valid = 1'b1; req1_operand = 32'h0000_0001; req1_shamt = 5'd31; req1_op = 1'b0;
      step(a0, a1);
      #3;
      chk("sll31_data", resp_data, 32'h8000_0000);
      chk("sll31_id", {31'd0, resp_id}, 32'd1);
      req1_operand = 32'h1234_5678; req1_shamt = 5'd0;
      step(a0, a1);
      req1_valid = 1'b0;
      #3;
      chk("sh0_data", resp_data, 32'h1234_5678);
      // Drain with no grant: register empties but data stays put.
      step(a0, a1);
      #3;
      chk("drain_valid", {31'd0, resp_valid}, 32'd0);
      chk("drain_data", resp_data, 32'h1234_5678);

      // Stall: full with resp_ready low for three cycles while both ports wait.
      new0(); new1();
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
      step(a0, a1);
      if (a0) new0();
      if (a1) new1();
      held_data = resp_data; held_id = resp_id;
      for (int i = 0; i < 3; i++) begin
         step(a0, a1);
         chk("stall_data", resp_data, held_data);
         chk("stall_id", {31'd0, resp_id}, {31'd0, held_id});
      end
      resp_ready = 1'b1;
      step(a0, a1);
      chk("stall_release_id", {31'd0, resp_id}, {31'd0, ~held_id});
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(a0, a1);
      step(a0, a1);

      // Asynchronous reset while holding a result from port 1.
      req1_valid = 1'b1; new1(); resp_ready = 1'b0;
      step(a0, a1);
      chk("prefill_id", {31'd0, resp_id}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, resp_valid}, 32'd0);
      chk("arst_data", resp_data, 32'd0);
      chk("arst_id", {31'd0, resp_id}, 32'd0);
      chk("arst_ready1", {31'd0, req1_ready}, 32'd0);
      sb.delete();
      m_full = 1'b0; m_prio = 1'b0; w0 = 0; w1 = 0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      new1();
      step(a0, a1);
      chk("post_rst_accept1", {31'd0, a1}, 32'd1);
      #3;
      chk("post_rst_id", {31'd0, resp_id}, 32'd1);
      req1_valid = 1'b0; resp_ready = 1'b1;
      step(a0, a1);

      // Random traffic: requests held until accepted, random consumer backpressure.
      for (int i = 0; i < 3000; i++) begin
         if (!req0_valid && $urandom_range(0, 3) != 0) begin req0_valid = 1'b1; new0(); end
         if (!req1_valid && $urandom_range(0, 3) != 0) begin req1_valid = 1'b1; new1(); end
         resp_ready = ($urandom_range(0, 3) != 0);
         step(a0, a1);
         if (a0) req0_valid = 1'b0;
         if (a1) req1_valid = 1'b0;
      end

      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      repeat (4) step(a0, a1);
      chk("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
